// File: rtl/bcd_digit_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_digit_sequencer
//
// Purpose:
//   Latches a packed-BCD word and a digit count, then presents the digits to
//   the VGA character renderer one at a time, most significant first, over a
//   valid/ready handshake. Owning the digit counter here keeps the number
//   storage block purely combinational.
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN - when defined, leading zero digits (except the
//   k=0 digit) are shown as BLANK_CODE until the first nonzero digit has
//   been sent. When undefined, every digit is shown as stored.
//
// Ports:
//   clk          in   1    system clock, all logic on posedge
//   rst          in   1    synchronous active-high reset
//   num_in       in   4*N  packed BCD word, digit k = num_in[4k+3:4k]
//   num_len      in   4    number of low-order digits to send (clamped to N)
//   start        in   1    request a sequence, sampled only when idle
//   abort        in   1    cancel the current sequence
//   digit_ready  in   1    renderer accepts the presented digit
//   digit_valid  out  1    digit_out/digit_idx/digit_last are valid
//   digit_out    out  4    current digit code
//   digit_idx    out  4    index k of the current digit
//   digit_last   out  1    current digit is k=0
//   busy         out  1    a sequence is in progress
//   done         out  1    one-cycle pulse after the last digit is accepted
//   err          out  1    sticky: length clamped or non-BCD nibble seen
// ---------------------------------------------------------------------------
module bcd_digit_sequencer #(
    parameter int         NUM_DIGITS = 10,
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter logic [3:0] BAD_CODE   = 4'hE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] num_in,
    input  logic [3:0]              num_len,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    digit_ready,
    output logic                    digit_valid,
    output logic [3:0]              digit_out,
    output logic [3:0]              digit_idx,
    output logic                    digit_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int         WORD_W  = 4 * NUM_DIGITS;
    localparam logic [3:0] MAX_LEN = 4'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [3:0]          idx_q, idx_d;
    logic                err_q, err_d;

    logic [3:0]          rawDigit;
    logic                isBad;
    logic                blankThis;
    logic [3:0]          digitCode;
    logic [3:0]          lenClamped;
    logic                lenTooBig;

`ifdef LEADING_ZERO_BLANK_EN
    // Set at the start of each sequence; stays set while only zeros have
    // been accepted by the renderer.
    logic                supp_q, supp_d;
`endif

    // Select the nibble addressed by the digit counter. The counter is kept
    // below NUM_DIGITS by the clamp at latch time, so no out-of-range read.
    always_comb begin
        rawDigit = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == 4'(k)) begin
                rawDigit = word_q[4*k +: 4];
            end
        end
    end

    // Map the raw nibble to the code shown on screen: non-BCD nibbles become
    // BAD_CODE, suppressed leading zeros become BLANK_CODE.
    always_comb begin
        isBad = (rawDigit > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        blankThis = supp_q && (rawDigit == 4'h0) && (idx_q != 4'd0);
`else
        blankThis = 1'b0;
`endif
        if (isBad) begin
            digitCode = BAD_CODE;
        end else if (blankThis) begin
            digitCode = BLANK_CODE;
        end else begin
            digitCode = rawDigit;
        end
    end

    // Length requested by the storage block, limited to the word size.
    always_comb begin
        lenTooBig  = (num_len > MAX_LEN);
        lenClamped = lenTooBig ? MAX_LEN : num_len;
    end

    // Next-state logic. Abort beats a same-cycle handshake; start is only
    // looked at while idle, so abort has no meaning there and start wins.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        err_d   = err_q;
`ifdef LEADING_ZERO_BLANK_EN
        supp_d  = supp_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d = num_in;
                    err_d  = lenTooBig;
`ifdef LEADING_ZERO_BLANK_EN
                    supp_d = 1'b1;
`endif
                    if (lenClamped == 4'd0) begin
                        idx_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        idx_d   = lenClamped - 4'd1;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (isBad) begin
                    err_d = 1'b1;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (digit_ready) begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (rawDigit != 4'h0) begin
                        supp_d = 1'b0;
                    end
`endif
                    if (idx_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            supp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef LEADING_ZERO_BLANK_EN
            supp_q  <= supp_d;
`endif
        end
    end

    // Digit outputs are forced to zero outside SEND so an idle sequencer
    // drives a clean all-zero bus.
    assign digit_valid = (state_q == SEND);
    assign digit_out   = digit_valid ? digitCode : 4'h0;
    assign digit_idx   = digit_valid ? idx_q : 4'd0;
    assign digit_last  = digit_valid && (idx_q == 4'd0);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;

endmodule
